// File: rtl/aes_ksc_pkg.sv
// Shared types and constants for the AES-128 key schedule controller.
// The optional round-key cache is enabled by defining KSC_KEY_CACHE_EN.
package aes_ksc_pkg;

  localparam int AES128_ROUNDS = 10;

  typedef logic [127:0] round_key_t;
  typedef logic [3:0]   round_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    EXPAND,
    FIN
  } ksc_state_t;

endpackage

// File: rtl/aes_ksc_key_cache.sv
// Round-key cache: one entry per round key, a valid bit, and a compare of
// the incoming cipher key against cached round key 0.
// Present only when KSC_KEY_CACHE_EN is defined.
`ifdef KSC_KEY_CACHE_EN
module aes_ksc_key_cache
  import aes_ksc_pkg::*;
#(
  parameter int DEPTH = AES128_ROUNDS + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  round_idx_t wr_idx,
  input  round_key_t wr_data,
  input  logic       set_valid,
  input  round_idx_t rd_idx,
  output round_key_t rd_data,
  input  round_key_t cmp_key,
  output logic       hit
);

  round_key_t mem [DEPTH];
  logic       valid;

  // Store every round key as it is handed to the consumer.
  // NOTE: the storage array is deliberately not reset; only the valid bit
  // needs clearing, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Valid once a complete schedule has been written; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)          valid <= 1'b0;
    else if (set_valid) valid <= 1'b1;
  end

  assign rd_data = mem[rd_idx];
  assign hit     = valid && (cmp_key == mem[0]);

endmodule
`endif

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key schedule controller: walks an external single-round key
// expansion datapath through rounds 1..NUM_ROUNDS and streams round keys
// 0..NUM_ROUNDS to the cipher core over valid/ready.
// Define KSC_KEY_CACHE_EN to add a round-key cache that replays a repeated key
// without running the datapath.
module aes_key_schedule_ctrl
  import aes_ksc_pkg::*;
#(
  parameter int NUM_ROUNDS  = AES128_ROUNDS,
  parameter int EXP_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  round_key_t key,
  output logic       busy,
  output logic       rk_valid,
  input  logic       rk_ready,
  output round_idx_t rk_round,
  output round_key_t rk_data,
  output logic       done,
  output round_key_t exp_key,
  output round_idx_t exp_round,
  input  round_key_t exp_rkey
);

  localparam int                LAT_W    = (EXP_LATENCY > 1) ? $clog2(EXP_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(EXP_LATENCY - 1);
  localparam round_idx_t        LAST_RND = round_idx_t'(NUM_ROUNDS);

  ksc_state_t       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept;
  logic             hit_run;
  round_key_t       cache_rd;
  round_idx_t       next_round;

  assign accept     = (state == EMIT) && rk_valid && rk_ready;
  assign next_round = rk_round + 4'd1;

`ifdef KSC_KEY_CACHE_EN
  logic cache_hit;

  aes_ksc_key_cache #(
    .DEPTH (NUM_ROUNDS + 1)
  ) u_cache (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (accept),
    .wr_idx    (rk_round),
    .wr_data   (rk_data),
    .set_valid (state == FIN),
    .rd_idx    (next_round),
    .rd_data   (cache_rd),
    .cmp_key   (key),
    .hit       (cache_hit)
  );

  // Latch the hit decision at start; it governs the whole schedule.
  always_ff @(posedge clk) begin
    if (reset)                      hit_run <= 1'b0;
    else if (state == IDLE && start) hit_run <= cache_hit;
  end
`else
  assign hit_run  = 1'b0;
  assign cache_rd = '0;
`endif

  // Main sequencer: all outputs are registered here.
  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge value of rk_round/rk_data regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      rk_round  <= '0;
      rk_data   <= '0;
      done      <= 1'b0;
      exp_key   <= '0;
      exp_round <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= EMIT;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            rk_round <= '0;
            rk_data  <= key;
          end
        end
        EMIT: begin
          if (accept) begin
            if (rk_round == LAST_RND) begin
              state    <= FIN;
              rk_valid <= 1'b0;
              done     <= 1'b1;
            end else if (hit_run) begin
              rk_round <= next_round;
              rk_data  <= cache_rd;
            end else begin
              state     <= EXPAND;
              rk_valid  <= 1'b0;
              lat_cnt   <= '0;
              exp_key   <= rk_data;
              exp_round <= next_round;
            end
          end
        end
        EXPAND: begin
          if (lat_cnt == LAT_LAST) begin
            state    <= EMIT;
            rk_valid <= 1'b1;
            rk_round <= exp_round;
            rk_data  <= exp_rkey;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
